// File: rtl/offchip_mem_arbiter.sv
// Round-robin two-requester read arbiter for the off-chip memory port, one transaction in flight.
// Optional WAIT timeout with error response: define ARB_TIMEOUT_EN.
module offchip_mem_arbiter #(
  parameter int AW             = 6,
  parameter int DW             = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          busy,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_data_rdy,
  input  logic [DW-1:0] mem_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          gnt, last, win, start, done, expire;
  logic [DW-1:0] resp_data;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) cnt <= '0;
    else if (state == WAIT)    cnt <= cnt + CW'(1);
  end
`endif

  // Tie goes to whoever was not served last; a lone requester always wins.
  assign win   = (req0 && req1) ? ~last : req1;
  assign start = (state == IDLE) && (req0 || req1);
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE:  if (req0 || req1) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mem_data_rdy) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        // Data arriving on the expiry cycle still takes the normal path.
        else if (cnt == CW'(TIMEOUT_CYCLES)) begin
          done      = 1'b1;
          expire    = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_data = expire ? '0 : mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_nxt;
      mem_rd_en <= start;
      ack0      <= done && !gnt;
      ack1      <= done && gnt;
      if (start) begin
        gnt      <= win;
        mem_addr <= win ? addr1 : addr0;
      end
      if (state == RESP) last <= gnt;
      if (done && !gnt)  rdata0 <= resp_data;
      if (done && gnt)   rdata1 <= resp_data;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= expire && !gnt;
      err1 <= expire && gnt;
    end
  end
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Bench for offchip_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model and a latency-5 memory model.
module tb_offchip_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          ack0, ack1, err0, err1, busy, mem_rd_en;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_data_rdy = 1'b0;
  logic [DW-1:0] mem_data = '0;

  always #5 clk = ~clk;

  offchip_mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data_rdy(mem_data_rdy), .mem_data(mem_data)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  // memory model state
  bit            pend = 0, mem_never = 0, inject = 0;
  int            pend_c = 0;
  logic [AW-1:0] pend_a = '0;

  // reference model: one transaction timeline (decision cycle, grant, latency)
  bit            m_act = 0, m_g = 0, m_last = 1, m_to = 0;
  int            m_s = 0, m_lat = 7;
  logic [AW-1:0] m_a = '0;
  logic          e_busy = 0, e_rd = 0, e_ack0 = 0, e_ack1 = 0, e_err0 = 0, e_err1 = 0;
  logic [AW-1:0] e_maddr = '0;
  logic [DW-1:0] e_r0 = '0, e_r1 = '0;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {32'hCAFE_0000, 26'd0, a};
  endfunction

  function automatic logic [139:0] obs_v();
    return {busy, mem_rd_en, ack0, ack1, err0, err1, mem_addr, rdata0, rdata1};
  endfunction

  function automatic logic [139:0] exp_v();
    return {e_busy, e_rd, e_ack0, e_ack1, e_err0, e_err1, e_maddr, e_r0, e_r1};
  endfunction

  // Account for the inputs of the cycle just ended, advance one cycle, drive memory, predict outputs.
  task automatic tick();
    if (rst) begin
      m_act = 0; m_last = 1; e_r0 = '0; e_r1 = '0; e_maddr = '0; pend = 0;
    end else if (m_act && cyc == m_s + m_lat) begin
      m_act = 0; m_last = m_g;
    end else if (!m_act && (req0 || req1)) begin
      m_g   = (req0 && req1) ? !m_last : req1;
      m_a   = m_g ? addr1 : addr0;
      m_act = 1; m_s = cyc; m_to = mem_never; m_lat = mem_never ? 19 : 7;
    end
    @(negedge clk);
    cyc++;
    mem_data_rdy = 1'b0;
    if (pend && cyc == pend_c + 5) begin
      mem_data_rdy = 1'b1; mem_data = mdata(pend_a); pend = 0;
    end else if (inject) begin
      mem_data_rdy = 1'b1; mem_data = {$urandom, $urandom};
    end
    if (mem_rd_en && !mem_never) begin
      pend = 1; pend_c = cyc; pend_a = mem_addr;
    end
    e_busy = m_act && cyc > m_s;
    e_rd   = m_act && cyc == m_s + 1;
    e_ack0 = m_act && cyc == m_s + m_lat && !m_g;
    e_ack1 = m_act && cyc == m_s + m_lat && m_g;
    e_err0 = e_ack0 && m_to;
    e_err1 = e_ack1 && m_to;
    if (e_rd) e_maddr = m_a;
    if (e_ack0) e_r0 = m_to ? '0 : mdata(m_a);
    if (e_ack1) e_r1 = m_to ? '0 : mdata(m_a);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      tick();
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_tests++; if (obs_v() !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs_v()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; tick();
    n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", obs_v(), exp_v()); end
  endtask

  task automatic test_single();
    int c0, c_ack = -1, c_rd = -1;
    req0 = 1'b1; addr0 = 6'h0A; c0 = cyc;
    repeat (12) begin
      tick();
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (mem_rd_en) c_rd = cyc;
      if (ack0) begin c_ack = cyc; req0 = 1'b0; end
    end
    n_tests++; if (c_rd - c0 !== 1) begin n_fail++; $display("FAIL single_rd_lat got=%0d exp=1", c_rd - c0); end
    n_tests++; if (c_ack - c0 !== 7) begin n_fail++; $display("FAIL single_ack_lat got=%0d exp=7", c_ack - c0); end
    n_tests++; if (rdata0 !== 64'hCAFE_0000_0000_000A) begin n_fail++; $display("FAIL single_rdata got=%h exp=cafe00000000000a", rdata0); end
  endtask

  task automatic test_contention();
    int c0, c_a0 = -1, c_a1 = -1;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'h01; addr1 = 6'h02; c0 = cyc;
    repeat (20) begin
      tick();
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (ack0) begin c_a0 = cyc; req0 = 1'b0; end
      if (ack1) begin c_a1 = cyc; req1 = 1'b0; end
    end
    n_tests++; if (c_a0 - c0 !== 7) begin n_fail++; $display("FAIL contention_ack0 got=%0d exp=7", c_a0 - c0); end
    n_tests++; if (c_a1 - c0 !== 15) begin n_fail++; $display("FAIL contention_ack1 got=%0d exp=15", c_a1 - c0); end
    n_tests++; if (rdata0 !== 64'hCAFE_0000_0000_0001) begin n_fail++; $display("FAIL contention_rdata0 got=%h", rdata0); end
    n_tests++; if (rdata1 !== 64'hCAFE_0000_0000_0002) begin n_fail++; $display("FAIL contention_rdata1 got=%h", rdata1); end
  endtask

  task automatic test_back_to_back();
    int who[$];
    int when[$];
    int n = 0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'($urandom); addr1 = 6'($urandom);
    while (who.size() < 8 && n < 100) begin
      tick(); n++;
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (ack0) begin who.push_back(0); when.push_back(cyc); addr0 = 6'($urandom); end
      if (ack1) begin who.push_back(1); when.push_back(cyc); addr1 = 6'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_tests++; if (who.size() != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", who.size()); end
    foreach (who[i]) begin
      n_tests++; if (who[i] != i % 2) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, who[i], i % 2); end
      if (i > 0) begin
        n_tests++; if (when[i] - when[i-1] != 8) begin n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=8", i, when[i] - when[i-1]); end
      end
    end
    drain(4);
  endtask

  task automatic test_reset_mid();
    int c_ack = -1;
    bit saw = 0;
    req0 = 1'b1; addr0 = 6'h15;
    repeat (4) begin
      tick();
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
    end
    rst = 1'b1; req0 = 1'b0;
    tick();
    rst = 1'b0;
    n_tests++; if (obs_v() !== '0) begin n_fail++; $display("FAIL rstmid_zero got=%h exp=0", obs_v()); end
    repeat (10) begin
      tick();
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (ack0 || ack1) saw = 1;
    end
    n_tests++; if (saw) begin n_fail++; $display("FAIL rstmid_noack got=1 exp=0"); end
    req0 = 1'b1; addr0 = 6'h2B;
    repeat (10) begin
      tick();
      if (ack0) begin c_ack = cyc; req0 = 1'b0; end
    end
    n_tests++; if (c_ack < 0 || rdata0 !== 64'hCAFE_0000_0000_002B) begin n_fail++; $display("FAIL rstmid_recover ack=%0d got=%h", c_ack, rdata0); end
  endtask

  task automatic test_spurious();
    logic [DW-1:0] s0, s1;
    bit saw = 0;
    s0 = rdata0; s1 = rdata1;
    inject = 1; tick(); inject = 0;
    repeat (4) begin
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL spurious cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (ack0 || ack1) saw = 1;
      tick();
    end
    n_tests++; if (saw || rdata0 !== s0 || rdata1 !== s1) begin n_fail++; $display("FAIL spurious_hold ack=%0b got=%h/%h exp=%h/%h", saw, rdata0, rdata1, s0, s1); end
  endtask

  task automatic test_random();
    repeat (800) begin
      tick();
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(3) == 0) begin req0 = 1'b1; addr0 = 6'($urandom); end
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(3) == 0) begin req1 = 1'b1; addr1 = 6'($urandom); end
    end
    drain(20);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c0, c_ack = -1;
    bit e1 = 0;
    mem_never = 1;
    req1 = 1'b1; addr1 = 6'h3F; c0 = cyc;
    repeat (24) begin
      tick();
      n_tests++; if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (ack1) begin c_ack = cyc; e1 = err1; req1 = 1'b0; end
    end
    mem_never = 0;
    n_tests++; if (c_ack - c0 !== 19) begin n_fail++; $display("FAIL timeout_lat got=%0d exp=19", c_ack - c0); end
    n_tests++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", e1); end
    n_tests++; if (rdata1 !== '0) begin n_fail++; $display("FAIL timeout_rdata got=%h exp=0", rdata1); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
